multicycle_control_unit: RTL

Multi-cycle RV32I control FSM that replaces the single-cycle opcode decoder in the multi-cycle CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states, drives all datapath strobes and mux selects per state, and stalls on instruction and data memory accesses. Memory completion comes either from a fixed latency or from a ready handshake. The block also counts retired instructions and halts on ECALL.

---
 rtl/multicycle_control_unit_if.sv | 55 +++++
 rtl/multicycle_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundles the signals between the multi-cycle RV32I control FSM and the
//   datapath/memory it steers.
//
//   Datapath -> control : opcode, bcond, halt_req, mem_ready
//   Control -> datapath : i_or_d, mem_read, mem_write, ir_write, reg_write,
//                         mem_to_reg, pc_to_reg, alu_src_a, alu_src_b,
//                         alu_op, pc_write, pc_source
//   Status              : is_ecall, is_halted, illegal_inst, state, instret
//
//   master : the control unit
//   slave  : the datapath / memory side
// ----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 bcond;
  logic                 halt_req;
  logic                 mem_ready;

  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 pc_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 pc_write;
  logic [1:0]           pc_source;

  logic                 is_ecall;
  logic                 is_halted;
  logic                 illegal_inst;
  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  opcode, bcond, halt_req, mem_ready,
    output i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
           pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_write, pc_source,
           is_ecall, is_halted, illegal_inst, state, instret
  );

  modport slave (
    output opcode, bcond, halt_req, mem_ready,
    input  i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
           pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_write, pc_source,
           is_ecall, is_halted, illegal_inst, state, instret
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//   Multi-cycle RV32I control FSM. Each instruction walks through
//   IF -> ID -> EX -> (MEM) -> (WB); the unit drives every datapath strobe and
//   mux select per state, stalls on instruction/data memory, counts retired
//   instructions and halts on ECALL when the datapath reports x17 == 10.
//
//   Parameters
//     MEM_HANDSHAKE : 1 = memory access ends on mem_ready,
//                     0 = memory access ends after MEM_LATENCY cycles
//     MEM_LATENCY   : cycles per access in fixed-latency mode (>= 1)
//     CNT_WIDTH     : width of the retired-instruction counter
//
//   Ports
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : control/datapath bundle (master side)
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter int MEM_LATENCY   = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  multicycle_control_unit_if.master  bus
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  // The wait counter only ever reaches MEM_LATENCY-1.
  localparam int                WAIT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CNT_WIDTH-1:0] instret;
  logic                 md;
  logic                 halt_retire;

  logic       mem_read_c, mem_write_c, ir_write_c, reg_write_c, pc_write_c;
  logic       i_or_d_c, mem_to_reg_c, pc_to_reg_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
  logic       is_ecall_c, is_halted_c, illegal_inst_c;

  assign md = MEM_HANDSHAKE ? bus.mem_ready : (wait_cnt == WAIT_LAST);

  // Output decode and next-state selection from state, opcode and memory-done.
  always_comb begin
    next_state     = state;
    halt_retire    = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    ir_write_c     = 1'b0;
    reg_write_c    = 1'b0;
    pc_write_c     = 1'b0;
    i_or_d_c       = 1'b0;
    mem_to_reg_c   = 1'b0;
    pc_to_reg_c    = 1'b0;
    alu_src_a_c    = 1'b0;
    alu_src_b_c    = 2'b00;
    alu_op_c       = 2'b00;
    pc_source_c    = 2'b00;
    is_ecall_c     = 1'b0;
    is_halted_c    = 1'b0;
    illegal_inst_c = 1'b0;

    case (state)
      S_IF: begin
        mem_read_c = 1'b1;
        ir_write_c = md;
        if (md) next_state = S_ID;
      end

      S_ID: begin
        next_state = S_EX;
        if (bus.opcode == OP_ECALL) begin
          is_ecall_c = 1'b1;
          if (bus.halt_req) begin
            next_state  = S_HALT;
            halt_retire = 1'b1;
          end
        end
      end

      S_EX: begin
        next_state = S_IF;
        case (bus.opcode)
          OP_ARITH, OP_ARITH_IMM: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = (bus.opcode == OP_ARITH_IMM) ? 2'b10 : 2'b00;
            alu_op_c    = 2'b10;
            next_state  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            next_state  = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = 2'b01;
            pc_write_c  = 1'b1;
            pc_source_c = bus.bcond ? 2'b01 : 2'b00;
          end
          OP_JAL: begin
            pc_write_c  = 1'b1;
            pc_source_c = 2'b01;
            reg_write_c = 1'b1;
            pc_to_reg_c = 1'b1;
          end
          OP_JALR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            pc_write_c  = 1'b1;
            pc_source_c = 2'b10;
            reg_write_c = 1'b1;
            pc_to_reg_c = 1'b1;
          end
          OP_ECALL: begin
            pc_write_c = 1'b1;
          end
          default: begin
            // Unknown opcodes retire as a NOP so the program keeps moving.
            illegal_inst_c = 1'b1;
            pc_write_c     = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = (bus.opcode == OP_LOAD);
        mem_write_c = (bus.opcode == OP_STORE);
        if (md) begin
          if (bus.opcode == OP_LOAD) begin
            next_state = S_WB;
          end else begin
            pc_write_c = 1'b1;
            next_state = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (bus.opcode == OP_LOAD);
        pc_write_c   = 1'b1;
        next_state   = S_IF;
      end

      S_HALT: begin
        is_halted_c = 1'b1;
      end

      default: begin
        next_state = S_IF;
      end
    endcase
  end

  // State, wait counter and retire counter. The wait counter is held at zero
  // outside a pending access, so it is already clear on every entry to IF/MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IF;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= next_state;
      if ((state == S_IF || state == S_MEM) && !md) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (pc_write_c || halt_retire) begin
        instret <= instret + CNT_WIDTH'(1);
      end
    end
  end

  // Write strobes are masked by reset itself so nothing can fire while the
  // async reset is held, even though the state already reads IF.
  assign bus.mem_read     = mem_read_c  & reset_n;
  assign bus.mem_write    = mem_write_c & reset_n;
  assign bus.ir_write     = ir_write_c  & reset_n;
  assign bus.reg_write    = reg_write_c & reset_n;
  assign bus.pc_write     = pc_write_c  & reset_n;
  assign bus.i_or_d       = i_or_d_c;
  assign bus.mem_to_reg   = mem_to_reg_c;
  assign bus.pc_to_reg    = pc_to_reg_c;
  assign bus.alu_src_a    = alu_src_a_c;
  assign bus.alu_src_b    = alu_src_b_c;
  assign bus.alu_op       = alu_op_c;
  assign bus.pc_source    = pc_source_c;
  assign bus.is_ecall     = is_ecall_c;
  assign bus.is_halted    = is_halted_c;
  assign bus.illegal_inst = illegal_inst_c;
  assign bus.state        = state;
  assign bus.instret      = instret;

endmodule
